fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage. Drives the PC register enable, the branch-select mux and the branch target into the fetch datapath. Handshakes with an instruction memory of variable latency. Arbitrates three events onto the single PC update port: sequential advance, decode back-pressure and execute-stage redirects. Sits between fetch, decode and execute, with a watchdog on memory latency.

---
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC sequencing, redirect arbitration and imem latency watchdog.
// Optional FETCH_CTRL_PERF_EN adds saturating WAIT/STALL cycle counters.
module fetch_ctrl #(
    parameter int N        = 64,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_D,
    input  logic         branch_taken_E,
    input  logic [N-1:0] branch_target_E,
    input  logic         imem_ready,
    output logic         imem_req,
    output logic         PCEnable,
    output logic         PCSrc_F,
    output logic [N-1:0] PCBranch_F,
    output logic         valid_F,
    output logic         flush_D,
    output logic         timeout_err
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_wait_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);
    localparam logic [2:0] BOOT = 3'd0, FETCH = 3'd1, WAIT = 3'd2, STALL = 3'd3, ERR = 3'd4;
    logic [2:0]       state, state_nx;
    logic             pend, pend_nx;
    logic [N-1:0]     pend_tgt, pend_tgt_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             redir, act;
    logic [N-1:0]     tgt;
    // the newest redirect always wins over a pending one
    assign redir       = pend | branch_taken_E;
    assign tgt         = branch_taken_E ? branch_target_E : pend_tgt;
    assign act         = (state == FETCH) || (state == WAIT) || (state == STALL);
    assign PCBranch_F  = act ? tgt : '0;
    assign flush_D     = act & branch_taken_E;
    assign timeout_err = (state == ERR);
    always_comb begin
        state_nx    = state;
        pend_nx     = pend;
        pend_tgt_nx = pend_tgt;
        wait_cnt_nx = wait_cnt;
        imem_req    = 1'b0;
        PCEnable    = 1'b0;
        PCSrc_F     = 1'b0;
        valid_F     = 1'b0;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH, WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    PCEnable    = redir | ~stall_D;
                    PCSrc_F     = redir;
                    valid_F     = ~redir;
                    pend_nx     = 1'b0;
                    wait_cnt_nx = '0;
                    state_nx    = (~redir & stall_D) ? STALL : FETCH;
                end else begin
                    pend_nx     = redir;
                    pend_tgt_nx = tgt;
                    wait_cnt_nx = (state == FETCH) ? CNT_W'(1) : wait_cnt + CNT_W'(1);
                    state_nx    = (state == WAIT && wait_cnt == CNT_W'(MAX_WAIT)) ? ERR : WAIT;
                end
            end
            STALL: begin
                valid_F  = ~redir;
                PCEnable = redir | ~stall_D;
                PCSrc_F  = redir;
                pend_nx  = 1'b0;
                state_nx = (redir | ~stall_D) ? FETCH : STALL;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pend     <= 1'b0;
            pend_tgt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            pend     <= pend_nx;
            pend_tgt <= pend_tgt_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end
`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_wait_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state == WAIT && ~&perf_wait_cnt) perf_wait_cnt <= perf_wait_cnt + 32'd1;
            if (state == STALL && ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed checks of fetch_ctrl against a behavioural model.
module tb_fetch_ctrl;
    localparam int N  = 64;
    localparam int MW = 15;
    logic         clk = 1'b0, reset = 1'b0;
    logic         stall_D = 1'b0, branch_taken_E = 1'b0, imem_ready = 1'b0;
    logic [N-1:0] branch_target_E = '0;
    logic         imem_req, PCEnable, PCSrc_F, valid_F, flush_D, timeout_err;
    logic [N-1:0] PCBranch_F;
    int vectors = 0, miscompares = 0;
    fetch_ctrl #(.N(N), .MAX_WAIT(MW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .stall_D(stall_D), .branch_taken_E(branch_taken_E),
        .branch_target_E(branch_target_E), .imem_ready(imem_ready), .imem_req(imem_req),
        .PCEnable(PCEnable), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F), .valid_F(valid_F),
        .flush_D(flush_D), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    // model: booted/dead/holding flags, cycles spent waiting, queue of unserved redirects
    bit           m_booted, m_dead, m_hold;
    int           m_waited;
    logic [N-1:0] m_q[$];
    logic [N-1:0] m_last;
    // layout: {req, en, src, valid, flush, timeout, branch}
    logic [69:0]  exp_v, obs_v;
    function automatic logic [69:0] outs();
        return {imem_req, PCEnable, PCSrc_F, valid_F, flush_D, timeout_err, PCBranch_F};
    endfunction
    function automatic void model_reset();
        m_booted = 0; m_dead = 0; m_hold = 0; m_waited = 0; m_q.delete(); m_last = '0;
    endfunction
    task automatic apply(input logic s, input logic b, input logic [N-1:0] t, input logic r);
        bit req = 0, en = 0, src = 0, vld = 0, fl = 0, to = 0, redirect;
        logic [N-1:0] pb = '0;
        stall_D = s; branch_taken_E = b; branch_target_E = t; imem_ready = r;
        if (!m_booted) m_booted = 1;
        else if (m_dead) to = 1;
        else begin
            redirect = (m_q.size() != 0) || b;
            pb = b ? t : m_last;
            fl = b;
            if (m_hold) begin
                if (redirect) begin en = 1; src = 1; m_hold = 0; m_q.delete(); end
                else if (!s) begin en = 1; vld = 1; m_hold = 0; end
                else vld = 1;
            end else begin
                req = 1;
                if (r) begin
                    en = redirect || !s; src = redirect; vld = !redirect;
                    m_hold = !redirect && s; m_q.delete(); m_waited = 0;
                end else begin
                    if (b) begin m_q.push_back(t); m_last = t; end
                    if (m_waited == MW) m_dead = 1; else m_waited++;
                end
            end
        end
        exp_v = {req, en, src, vld, fl, to, pb};
        @(negedge clk);
        obs_v = outs();
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        stall_D = 1'b1; branch_taken_E = 1'b1; branch_target_E = 64'hdead_beef; imem_ready = 1'b1;
        #2;
        vectors++;
        if (outs() !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", outs());
        end
        reset = 1'b1;
        model_reset();
    endtask
    task automatic test_sequential();
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL seq_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            vectors++;
            if (obs_v[69:66] !== ((i == 0) ? 4'b0000 : 4'b1101)) begin
                miscompares++;
                $display("FAIL seq_req_en_src_valid cyc=%0d got=%b want=%b", i, obs_v[69:66],
                         (i == 0) ? 4'b0000 : 4'b1101);
            end
        end
    endtask
    task automatic test_wait();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, '0, i == 3);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL wait_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            vectors++;
            if ({obs_v[69], obs_v[68], obs_v[66]} !== {1'b1, i == 3, i == 3}) begin
                miscompares++;
                $display("FAIL wait_req_en_valid cyc=%0d got=%b want=%b", i,
                         {obs_v[69], obs_v[68], obs_v[66]}, {1'b1, i == 3, i == 3});
            end
        end
    endtask
    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            apply(i != 2, 1'b0, '0, i == 0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL stall_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            vectors++;
            if ({obs_v[69], obs_v[68], obs_v[66]} !== {i == 0, i == 2, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_req_en_valid cyc=%0d got=%b want=%b", i,
                         {obs_v[69], obs_v[68], obs_v[66]}, {i == 0, i == 2, 1'b1});
            end
        end
    endtask
    task automatic test_branch_wait();
        logic [N-1:0] tg[5] = '{64'h0, 64'h1000, 64'h0, 64'h2000, 64'h0};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, i == 1 || i == 3, tg[i], i == 4);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL brwait_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            vectors++;
            if (obs_v[65] !== (i == 1 || i == 3)) begin
                miscompares++;
                $display("FAIL brwait_flush cyc=%0d got=%b want=%b", i, obs_v[65], i == 1 || i == 3);
            end
        end
        vectors++;
        if ({obs_v[68:66], obs_v[63:0]} !== {3'b110, 64'h2000}) begin
            miscompares++;
            $display("FAIL brwait_apply got=%h want=%h", {obs_v[68:66], obs_v[63:0]}, {3'b110, 64'h2000});
        end
    endtask
    task automatic test_branch_stall();
        logic [66:0] want[3] = '{{3'b001, 64'h0}, {3'b110, 64'h40}, {3'b101, 64'h40}};
        for (int i = 0; i < 3; i++) begin
            apply(i != 2, i == 1, (i == 1) ? 64'h40 : 64'h0, i != 1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL brstall_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
        vectors++;
        if (exp_v[65] !== 1'b0 || obs_v[69] !== 1'b1) begin
            miscompares++;
            $display("FAIL brstall_refetch req=%b want=1", obs_v[69]);
        end
        apply(1'b1, 1'b0, '0, 1'b1);
        apply(1'b1, 1'b1, 64'h40, 1'b0);
        vectors++;
        if ({obs_v[68:65], obs_v[63:0]} !== {4'b1101, 64'h40}) begin
            miscompares++;
            $display("FAIL brstall_redirect got=%h want=%h", {obs_v[68:65], obs_v[63:0]}, {4'b1101, 64'h40});
        end
        if (want[0][66] !== 1'b0) $display("note: table layout changed");
    endtask
    task automatic test_timeout();
        reset = 1'b0; #2; reset = 1'b1; model_reset();
        apply(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL timeout_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            vectors++;
            if ({obs_v[69], obs_v[64]} !== ((i < 16) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL timeout_req_err cyc=%0d got=%b want=%b", i, {obs_v[69], obs_v[64]},
                         (i < 16) ? 2'b10 : 2'b01);
            end
        end
        apply(1'b0, 1'b0, '0, 1'b1);
        reset = 1'b0;
        #2;
        vectors++;
        if (timeout_err !== 1'b0 || outs() !== 70'd0) begin
            miscompares++;
            $display("FAIL timeout_async_clear got=%h want=0", outs());
        end
        reset = 1'b1;
        model_reset();
    endtask
    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 9) < 4, $urandom_range(0, 5) == 0,
                  {$urandom, $urandom}, $urandom_range(0, 9) < 6);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (m_dead && $urandom_range(0, 3) == 0) begin
                reset = 1'b0; #2; reset = 1'b1; model_reset();
            end
        end
    endtask
    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_branch_wait();
        test_branch_stall();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
